decodificador_hamming: RTL and testbench
========================================

# decodificador_hamming

Pipelined Hamming(7,4) single-error-correcting decoder on the receive side of the link. It takes 7-bit codewords in the bit layout produced by our Hamming(7,4) encoder, computes the 3-bit syndrome, flips the erroneous bit and outputs the 4 data bits. It has valid/ready handshakes on both sides and a saturating corrected-error counter that status logic reads.

## Interface

Parameters:
- COUNT_W, 8: width of the corrected-error counter.

Ports:
- clk, input, 1: clock. Everything is rising-edge.
- rst, input, 1: reset, asynchronous and active-high.
- in_valid, input, 1: code_in holds a codeword.
- in_ready, output, 1: decoder can accept a codeword.
- code_in, input, 7: received codeword. Bits [0],[1],[3] are parity p1,p2,p4. Bits [2],[4],[5],[6] are data d0..d3.
- out_valid, output, 1: data_out, syndrome_out and corrected are valid.
- out_ready, input, 1: downstream accepts the output.
- data_out, output, 4: corrected data {d3,d2,d1,d0}.
- syndrome_out, output, 3: syndrome {s2,s1,s0}.
- corrected, output, 1: syndrome was nonzero, so one bit was flipped.
- err_count, output, COUNT_W: saturating count of consumed outputs with corrected=1.
- clr_count, input, 1: synchronous clear of err_count.

## Operation

- Syndrome:
  - s0 = c0^c2^c4^c6
  - s1 = c1^c2^c5^c6
  - s2 = c3^c4^c5^c6
  - Value S = {s2,s1,s0}. S≠0 means code bit S−1 is wrong.
- Correction:
  - cc = c ^ (S≠0 ? 1<<(S−1) : 0).
  - data_out = {cc[6],cc[5],cc[4],cc[2]}.
  - If S points to a parity bit (S=1,2,4), data_out equals the received data bits and corrected=1.
- Double errors are miscorrected. This is a Hamming(7,4) limitation, not detected and not flagged.
- Pipeline stages:
  - Stage 1 registers the codeword and the syndrome. The register is s1_valid.
  - Stage 2 registers data_out, syndrome_out and corrected. The register is s2_valid = out_valid.
- Handshake:
  - A transfer happens when valid && ready is high on a rising edge.
  - Stage 2 may load when !s2_valid || out_ready.
  - Stage 1 may load when !s1_valid || stage 2 may load.
  - in_ready = !s1_valid || stage 2 may load. in_ready is combinational from out_ready and the valid registers, with no path from in_valid.
  - Outputs hold stable while out_valid && !out_ready.
- err_count:
  - +1 on each output transfer with corrected=1.
  - Saturates at 2^COUNT_W−1.
  - clr_count has priority: clear and increment in the same cycle gives 0.

## Timing

- Reset values:
  - s1_valid=0, out_valid=0.
  - data_out=0, syndrome_out=0, corrected=0, err_count=0.
  - in_ready reads 1 once reset is released.
- Latency: accept at edge N gives out_valid at edge N+2 when no stall occurs.
- Throughput: one word per cycle while out_ready=1.
- Stall:
  - out_ready=0 with both stages full: in_ready=0 the same cycle.
  - Up to 2 words are buffered, with no loss and no duplication.
- Simultaneous events: an output transfer and a stage-1→2 move on the same edge is a legal pass-through.
- Reset mid-operation: in-flight words are discarded, valids clear immediately (asynchronous), and err_count clears.
- Data/syndrome registers need no reset for function, but are reset to 0 for determinism.

## Structure

- Shared package hamming_pkg holds:
  - CODE_W=7, DATA_W=4, SYN_W=3.
  - Localparams for the parity bit indices.
  - A function computing the syndrome.
  - A function extracting data from a codeword.
- These are reused by the encoder testbench as a reference model.
- One sub-module is natural: sindrome_hamming, a combinational 7→3 syndrome plus correction mask. The top holds the pipeline registers, handshake and counter.

## Test plan

- Clean words: data 4'hB encodes to 7'h55 → data_out=4'hB, syndrome 0, corrected=0, err_count unchanged. Same check for 4'h0→7'h00 and 4'hF→7'h7F.
- Single data-bit error: 7'h45 (bit 4 flipped from 7'h55) → data_out=4'hB, syndrome=3'd5, corrected=1, err_count +1.
- Parity-bit error: 7'h54 (bit 0 flipped) → data_out=4'hB, syndrome=3'd1, corrected=1.
- Exhaustive: all 16 data values × all 8 error patterns (none or one bit flipped), streamed back-to-back with out_ready=1 → all decode correctly, one result per cycle, latency 2.
- Backpressure: random out_ready with continuous in_valid → order preserved, outputs stable while stalled, in_ready=0 only when both stages are full.
- Counter: with COUNT_W=2, send 5 corrupted words → err_count saturates at 3. clr_count asserted in the same cycle as a corrected transfer → err_count=0. Assert rst mid-stream → out_valid=0 asynchronously.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: widths, bit positions and reference functions.
// Used by the receive-side decoder and by the encoder bench as a model.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int D0_IDX = 2;
  localparam int P4_IDX = 3;
  localparam int D1_IDX = 4;
  localparam int D2_IDX = 5;
  localparam int D3_IDX = 6;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SYN_W-1:0]  syn_t;

  function automatic syn_t calc_syndrome(input code_t c);
    syn_t s;
    s[0] = c[P1_IDX] ^ c[D0_IDX] ^ c[D1_IDX] ^ c[D3_IDX];
    s[1] = c[P2_IDX] ^ c[D0_IDX] ^ c[D2_IDX] ^ c[D3_IDX];
    s[2] = c[P4_IDX] ^ c[D1_IDX] ^ c[D2_IDX] ^ c[D3_IDX];
    return s;
  endfunction

  function automatic data_t extract_data(input code_t c);
    return {c[D3_IDX], c[D2_IDX], c[D1_IDX], c[D0_IDX]};
  endfunction

  // A nonzero syndrome S names code bit S-1 as the flipped one.
  function automatic code_t syn_mask(input syn_t s);
    code_t m;
    m = '0;
    if (s != '0) m = code_t'(1) << (s - SYN_W'(1));
    return m;
  endfunction

  function automatic code_t encode_data(input data_t d);
    code_t c;
    c = '0;
    c[D0_IDX] = d[0];
    c[D1_IDX] = d[1];
    c[D2_IDX] = d[2];
    c[D3_IDX] = d[3];
    c[P1_IDX] = d[0] ^ d[1] ^ d[3];
    c[P2_IDX] = d[0] ^ d[2] ^ d[3];
    c[P4_IDX] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

endpackage

// File: rtl/decodificador_hamming_if.sv
// Valid/ready bundle between the link receiver, the decoder and the downstream consumer.
// The master side drives codewords in and accepts decoded words out.
interface decodificador_hamming_if
  import hamming_pkg::*;
#(
  parameter int COUNT_W = 8
) ();

  logic               in_valid;
  logic               in_ready;
  code_t              code_in;
  logic               out_valid;
  logic               out_ready;
  data_t              data_out;
  syn_t               syndrome_out;
  logic               corrected;
  logic [COUNT_W-1:0] err_count;
  logic               clr_count;

  modport master (
    output in_valid, code_in, out_ready, clr_count,
    input  in_ready, out_valid, data_out, syndrome_out, corrected, err_count
  );

  modport slave (
    input  in_valid, code_in, out_ready, clr_count,
    output in_ready, out_valid, data_out, syndrome_out, corrected, err_count
  );

endinterface

// File: rtl/decodificador_hamming_sindrome.sv
// Combinational 7->3 syndrome and the single-bit correction mask it implies.
module sindrome_hamming
  import hamming_pkg::*;
(
  input  code_t code_i,
  output syn_t  syn_o,
  output code_t mask_o
);

  assign syn_o  = calc_syndrome(code_i);
  assign mask_o = syn_mask(syn_o);

endmodule

// File: rtl/decodificador_hamming.sv
// Two-stage Hamming(7,4) decoder: stage 1 holds codeword+syndrome, stage 2 the corrected data.
// Full skid-free valid/ready pipeline with a saturating corrected-error counter.
module decodificador_hamming
  import hamming_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input logic clk,
  input logic rst,
  decodificador_hamming_if.slave bus
);

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  logic               s1_valid_q, s1_valid_d;
  code_t              s1_code_q,  s1_code_d;
  syn_t               s1_syn_q,   s1_syn_d;
  code_t              s1_mask_q,  s1_mask_d;
  logic               s2_valid_q, s2_valid_d;
  data_t              s2_data_q,  s2_data_d;
  syn_t               s2_syn_q,   s2_syn_d;
  logic               s2_corr_q,  s2_corr_d;
  logic [COUNT_W-1:0] cnt_q,      cnt_d;

  syn_t  in_syn;
  code_t in_mask;
  logic  s2_load, s1_load, in_xfer, out_xfer;

  sindrome_hamming u_sindrome (
    .code_i (bus.code_in),
    .syn_o  (in_syn),
    .mask_o (in_mask)
  );

  // Ready only looks at state and out_ready so it never depends on in_valid.
  assign s2_load  = !s2_valid_q || bus.out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_xfer  = bus.in_valid && s1_load;
  assign out_xfer = s2_valid_q && bus.out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_mask_d  = s1_mask_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_syn_d   = s2_syn_q;
    s2_corr_d  = s2_corr_q;
    cnt_d      = cnt_q;

    if (s1_load) s1_valid_d = bus.in_valid;
    if (in_xfer) begin
      s1_code_d = bus.code_in;
      s1_syn_d  = in_syn;
      s1_mask_d = in_mask;
    end

    if (s2_load) s2_valid_d = s1_valid_q;
    if (s2_load && s1_valid_q) begin
      s2_data_d = extract_data(s1_code_q ^ s1_mask_q);
      s2_syn_d  = s1_syn_q;
      s2_corr_d = (s1_syn_q != '0);
    end

    if (bus.clr_count) begin
      cnt_d = '0;
    end else if (out_xfer && s2_corr_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_mask_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_syn_q   <= '0;
      s2_corr_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_code_q  <= s1_code_d;
      s1_syn_q   <= s1_syn_d;
      s1_mask_q  <= s1_mask_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_syn_q   <= s2_syn_d;
      s2_corr_q  <= s2_corr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready     = s1_load;
  assign bus.out_valid    = s2_valid_q;
  assign bus.data_out     = s2_data_q;
  assign bus.syndrome_out = s2_syn_q;
  assign bus.corrected    = s2_corr_q;
  assign bus.err_count    = cnt_q;

endmodule

// File: tb/tb_decodificador_hamming.sv
// Directed bench for decodificador_hamming with a 2-bit counter so saturation is reachable.
module tb_decodificador_hamming;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  decodificador_hamming_if #(.COUNT_W(2)) bus ();

  decodificador_hamming #(.COUNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Independent encoder: d0..d3 at bits 2,4,5,6; p1,p2,p4 at bits 0,1,3.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Word k: data k/8, error pattern k%8 (0 = clean, else flip bit e-1).
  function automatic logic [6:0] make_code(input int k);
    logic [6:0] c;
    int e;
    c = enc(4'((k / 8) % 16));
    e = k % 8;
    if (e != 0) c[e-1] = ~c[e-1];
    return c;
  endfunction

  function automatic logic [7:0] make_exp(input int k);
    return {4'((k / 8) % 16), 3'(k % 8), ((k % 8) != 0)};
  endfunction

  function automatic logic [7:0] cur_out();
    return {bus.data_out, bus.syndrome_out, bus.corrected};
  endfunction

  task automatic send_one(input logic [6:0] code, input logic [7:0] exp, input string tag);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.code_in  = code;
    #1 chk({tag, "_rdy"}, bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_lat1"}, bus.out_valid, 0);
    @(negedge clk);
    chk({tag, "_vld"}, bus.out_valid, 1);
    chk({tag, "_out"}, cur_out(), exp);
    @(negedge clk);
    chk({tag, "_nodup"}, bus.out_valid, 0);
  endtask

  task automatic clear_count();
    @(negedge clk);
    bus.clr_count = 1'b1;
    @(negedge clk);
    bus.clr_count = 1'b0;
    chk("clr", bus.err_count, 0);
  endtask

  logic [7:0] expq[$];
  int         sent, got, occ;
  logic       in_x, out_x;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.code_in   = '0;
    bus.out_ready = 1'b1;
    bus.clr_count = 1'b0;

    #12;
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_out", cur_out(), 0);
    chk("rst_cnt", bus.err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_rdy", bus.in_ready, 1);

    // Directed words: {data, syndrome, corrected}
    send_one(7'h55, {4'hB, 3'd0, 1'b0}, "clean_b");
    send_one(7'h00, {4'h0, 3'd0, 1'b0}, "clean_0");
    send_one(7'h7F, {4'hF, 3'd0, 1'b0}, "clean_f");
    chk("cnt_clean", bus.err_count, 0);
    send_one(7'h45, {4'hB, 3'd5, 1'b1}, "dbit4");
    chk("cnt_dbit", bus.err_count, 1);
    send_one(7'h54, {4'hB, 3'd1, 1'b1}, "pbit0");
    chk("cnt_pbit", bus.err_count, 2);

    // All 16 data values x 8 error patterns back-to-back, latency 2.
    for (int k = 0; k < 130; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk("ex_vld", bus.out_valid, 1);
        chk("ex_out", cur_out(), make_exp(k - 2));
      end else begin
        chk("ex_lat", bus.out_valid, 0);
      end
      if (k < 128) begin
        bus.in_valid = 1'b1;
        bus.code_in  = make_code(k);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (k < 128) chk("ex_rdy", bus.in_ready, 1);
    end
    @(negedge clk);
    chk("ex_drained", bus.out_valid, 0);
    chk("ex_cnt_sat", bus.err_count, 3);
    clear_count();

    // Random backpressure with continuous input.
    sent = 0;
    got  = 0;
    occ  = 0;
    for (int cyc = 0; cyc < 90; cyc++) begin
      @(negedge clk);
      bus.in_valid  = (cyc < 60);
      bus.code_in   = make_code(sent + 9);
      bus.out_ready = (cyc < 70) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("bp_rdy", bus.in_ready, !(occ == 2 && !bus.out_ready));
      if (bus.out_valid) begin
        if (expq.size() > 0) chk("bp_out", cur_out(), expq[0]);
        else chk("bp_spurious", bus.out_valid, 0);
      end
      in_x  = bus.in_valid && bus.in_ready;
      out_x = bus.out_valid && bus.out_ready;
      if (out_x && expq.size() > 0) begin
        void'(expq.pop_front());
        got++;
      end
      if (in_x) begin
        expq.push_back(make_exp(sent + 9));
        sent++;
      end
      occ = occ + int'(in_x) - int'(out_x);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_count", got, sent);
    chk("bp_left", expq.size(), 0);
    clear_count();

    // Five corrupted words saturate the 2-bit counter at 3.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.code_in  = make_code(8 * k + 3);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_cnt", bus.err_count, 3);
    clear_count();

    // Clear coinciding with a corrected transfer wins.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.code_in  = 7'h45;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("prio_vld", bus.out_valid, 1);
    bus.clr_count = 1'b1;
    @(negedge clk);
    bus.clr_count = 1'b0;
    chk("prio_cnt", bus.err_count, 0);
    send_one(7'h54, {4'hB, 3'd1, 1'b1}, "post_clr");
    chk("post_clr_cnt", bus.err_count, 1);

    // Reset while the pipeline is full and stalled.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.code_in  = make_code(k + 17);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_pre_vld", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_vld", bus.out_valid, 0);
    chk("mid_cnt", bus.err_count, 0);
    chk("mid_rdy", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_flushed", bus.out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
